// File: rtl/serial_stream_tx_if.sv
// Host write port of the serial stream transmitter.
//   wr_valid  : host has a word to write
//   wr_ready  : transmitter FIFO can accept a word (not full)
//   wr_data   : 32-bit word, byte0 = [7:0] goes out first
//   wr_chan   : 0 = weight channel, 1 = line channel
//   wr_nbytes : valid low bytes in the word, 0 encodes 4
// master = host glue, slave = transmitter.
interface serial_stream_tx_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_chan;
  logic [1:0]  wr_nbytes;

  modport master (output wr_valid, wr_data, wr_chan, wr_nbytes, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_chan, wr_nbytes, output wr_ready);
endinterface

// File: rtl/serial_stream_tx.sv
// Byte-serial transmitter feeding the CNN accelerator's weight and line
// input channels. Words from the host are queued in a small FIFO, then
// unpacked LSB byte first onto one of two strobed byte channels. The
// accelerator cannot stall us, so pacing comes from the programmable gap.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   wr                  : host write port (slave side)
//   gap                 : idle cycles after each byte, sampled per byte
//   flush               : sync abort of FIFO, current word and byte count
//   serial_weight_*     : weight channel byte + one-cycle strobe
//   serial_line_*       : line channel byte + one-cycle strobe
//   busy                : FIFO non-empty or a word in flight
//   fifo_level          : occupied FIFO entries
//   bytes_sent          : bytes emitted since reset/flush (wraps)
module serial_stream_tx #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  serial_stream_tx_if.slave        wr,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     flush,
  output logic [7:0]               serial_weight_data,
  output logic                     serial_weight_valid,
  output logic [7:0]               serial_line_data,
  output logic                     serial_line_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         bytes_sent
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic        chan;
    logic [1:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push, pop, load, emit;
  entry_t            head;
  state_t            state, nxt;
  logic [31:0]       shreg;
  logic [2:0]        rem;
  logic              cur_chan;
  logic [GAP_W-1:0]  gap_cnt;

  assign full        = (fifo_level == LW'(DEPTH));
  assign empty       = (fifo_level == '0);
  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && !full;
  assign head        = mem[rd_ptr];
  assign busy        = !empty || (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (!empty) nxt = SEND;
      SEND: begin
        if (rem != 3'd1)        nxt = (gap != '0) ? WAIT : SEND;
        else if (gap != '0)     nxt = WAIT;
        else if (!empty)        nxt = SEND;  // chain next word, no bubble
        else                    nxt = IDLE;
      end
      WAIT: if (gap_cnt <= GAP_W'(1)) nxt = (rem != '0) ? SEND : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // datapath controls
  always_comb begin
    emit = (state == SEND);
    load = 1'b0;
    case (state)
      IDLE:    load = !empty;
      SEND:    load = (rem == 3'd1) && (gap == '0) && !empty;
      default: load = 1'b0;
    endcase
    pop = load;
  end

  // FIFO storage needs no reset; pointers/level define validity
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{chan: wr.wr_chan, nbytes: wr.wr_nbytes, data: wr.wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_level          <= '0;
      shreg               <= '0;
      rem                 <= '0;
      cur_chan            <= 1'b0;
      gap_cnt             <= '0;
      serial_weight_data  <= '0;
      serial_weight_valid <= 1'b0;
      serial_line_data    <= '0;
      serial_line_valid   <= 1'b0;
      bytes_sent          <= '0;
    end else if (flush) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_level          <= '0;
      rem                 <= '0;
      gap_cnt             <= '0;
      serial_weight_valid <= 1'b0;
      serial_line_valid   <= 1'b0;
      bytes_sent          <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);

      // when the last byte chains into the next word, the output below
      // still takes the old shreg; the load simply wins the register
      if (load) begin
        shreg    <= head.data;
        rem      <= (head.nbytes == 2'd0) ? 3'd4 : {1'b0, head.nbytes};
        cur_chan <= head.chan;
      end else if (emit) begin
        shreg <= {8'h00, shreg[31:8]};
        rem   <= rem - 3'd1;
      end

      serial_weight_valid <= emit && !cur_chan;
      serial_line_valid   <= emit &&  cur_chan;
      if (emit && !cur_chan) serial_weight_data <= shreg[7:0];
      if (emit &&  cur_chan) serial_line_data   <= shreg[7:0];
      if (emit) bytes_sent <= bytes_sent + 1'b1;

      if (emit)               gap_cnt <= gap;
      else if (state == WAIT) gap_cnt <= gap_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_stream_tx.sv
module tb_serial_stream_tx;
  localparam int DEPTH = 4;
  localparam int GAP_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [GAP_W-1:0] gap;
  logic flush;
  logic [7:0] serial_weight_data, serial_line_data;
  logic serial_weight_valid, serial_line_valid, busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0] bytes_sent;

  serial_stream_tx_if wr_if();

  serial_stream_tx #(.DEPTH(DEPTH), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr_if), .gap(gap), .flush(flush),
    .serial_weight_data(serial_weight_data), .serial_weight_valid(serial_weight_valid),
    .serial_line_data(serial_line_data), .serial_line_valid(serial_line_valid),
    .busy(busy), .fifo_level(fifo_level), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // scoreboard: one entry per expected byte
  typedef struct {
    bit         chan;
    logic [7:0] data;
    int         space;    // idle cycles since previous byte, -1 = don't care
    int         abs_cyc;  // exact cycle of the strobe, -1 = don't care
  } exp_t;
  exp_t exp_q[$];
  int last_cyc = 0;

  always @(negedge clk) begin
    if (reset_n && (serial_weight_valid || serial_line_valid)) begin
      exp_t e;
      chk("no_overlap", {31'd0, serial_weight_valid & serial_line_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_byte: got w=%0b/%0h l=%0b/%0h expected none", serial_weight_valid,
                 serial_weight_data, serial_line_valid, serial_line_data);
      end else begin
        e = exp_q.pop_front();
        chk("byte_chan", {31'd0, serial_line_valid}, {31'd0, e.chan});
        chk("byte_data", {24'd0, e.chan ? serial_line_data : serial_weight_data}, {24'd0, e.data});
        if (e.space >= 0)   chk("byte_space", cyc - last_cyc - 1, e.space);
        if (e.abs_cyc >= 0) chk("byte_latency", cyc, e.abs_cyc);
      end
      last_cyc = cyc;
    end
  end

  task automatic exp_word(input logic [31:0] d, input bit c, input int n,
                          input int first_space, input int first_abs, input int g);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.chan    = c;
      e.data    = d[8*i +: 8];
      e.space   = (i == 0) ? first_space : g;
      e.abs_cyc = (i == 0) ? first_abs : -1;
      exp_q.push_back(e);
    end
  endtask

  // one write attempt lasting exactly one edge; acc reflects the handshake
  task automatic put(input logic [31:0] d, input bit c, input logic [1:0] nb,
                     output bit acc, output int acc_cyc);
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_data   = d;
    wr_if.wr_chan   = c;
    wr_if.wr_nbytes = nb;
    acc = wr_if.wr_ready;
    @(posedge clk); #1;
    acc_cyc = cyc;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    bit          chan;
    logic [1:0]  nb;
    logic [3:0]  g;
    int          exp_n;   // bytes expected on the channel
  } vec_t;

  int bs_model = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    bit acc;
    int ac;
    logic [31:0] w;

    vt[0] = '{32'h44332211, 1'b0, 2'd0, 4'd0,  4};
    vt[1] = '{32'hAABBCCDD, 1'b1, 2'd2, 4'd2,  2};
    vt[2] = '{32'h0000005A, 1'b0, 2'd1, 4'd1,  1};
    vt[3] = '{32'h00C3B2A1, 1'b1, 2'd3, 4'd0,  3};
    vt[4] = '{32'h12345678, 1'b1, 2'd0, 4'd15, 4};
    vt[5] = '{32'h89ABCDEF, 1'b0, 2'd3, 4'd1,  3};

    reset_n = 1'b0; flush = 1'b0; gap = '0;
    wr_if.wr_valid = 1'b0; wr_if.wr_data = '0; wr_if.wr_chan = 1'b0; wr_if.wr_nbytes = '0;
    step(3);
    chk("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_wvalid", {31'd0, serial_weight_valid}, 32'd0);
    chk("rst_lvalid", {31'd0, serial_line_valid}, 32'd0);
    chk("rst_wdata", {24'd0, serial_weight_data}, 32'd0);
    chk("rst_ldata", {24'd0, serial_line_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bytes", {16'd0, bytes_sent}, 32'd0);
    reset_n = 1'b1;
    step(2);

    // single words into an idle engine: latency, byte order, nbytes, gap
    for (int i = 0; i < 6; i++) begin
      gap = vt[i].g;
      put(vt[i].data, vt[i].chan, vt[i].nb, acc, ac);
      chk("vec_accept", {31'd0, acc}, 32'd1);
      exp_word(vt[i].data, vt[i].chan, vt[i].exp_n, -1, ac + 2, vt[i].g);
      bs_model += vt[i].exp_n;
      drain(200);
      chk("vec_bytes_sent", {16'd0, bytes_sent}, bs_model);
      step(1);
    end

    // fill: engine held by a slow word while the FIFO fills up
    gap = 4'd3;
    put(32'h03020100, 1'b0, 2'd0, acc, ac);
    exp_word(32'h03020100, 1'b0, 4, -1, -1, 3);
    step(1);
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'h10203040 + 32'h01010101 * i;
      put(w, i[0], 2'd0, acc, ac);
      chk("fill_accept", {31'd0, acc}, 32'd1);
      exp_word(w, i[0], 4, -1, -1, 3);
    end
    chk("fill_level", {29'd0, fifo_level}, DEPTH);
    chk("fill_ready_low", {31'd0, wr_if.wr_ready}, 32'd0);
    put(32'hDEADBEEF, 1'b0, 2'd0, acc, ac);
    chk("fill_extra_rejected", {31'd0, acc}, 32'd0);
    chk("fill_level_hold", {29'd0, fifo_level}, DEPTH);
    bs_model += 4 * (DEPTH + 1);
    drain(400);
    chk("fill_bytes_sent", {16'd0, bytes_sent}, bs_model);

    // alternating channels, gap 0: no bubbles across word boundaries
    gap = 4'd0;
    put(32'hA3A2A1A0, 1'b0, 2'd0, acc, ac); exp_word(32'hA3A2A1A0, 1'b0, 4, -1, -1, 0);
    put(32'hFFB2B1B0, 1'b1, 2'd3, acc, ac); exp_word(32'hFFB2B1B0, 1'b1, 3, 0, -1, 0);
    put(32'hFFFFFFC0, 1'b0, 2'd1, acc, ac); exp_word(32'hFFFFFFC0, 1'b0, 1, 0, -1, 0);
    put(32'hFFFFD1D0, 1'b1, 2'd2, acc, ac); exp_word(32'hFFFFD1D0, 1'b1, 2, 0, -1, 0);
    bs_model += 10;
    drain(200);
    chk("alt_bytes_sent", {16'd0, bytes_sent}, bs_model);

    // flush during the third byte with two words still queued
    put(32'h0D0C0B0A, 1'b0, 2'd0, acc, ac);
    put(32'h1D1C1B1A, 1'b1, 2'd0, acc, ac);
    put(32'h2D2C2B2A, 1'b0, 2'd0, acc, ac);
    exp_word(32'h0D0C0B0A, 1'b0, 3, -1, -1, 0);
    begin
      int n = 0;
      while (!(serial_weight_valid && serial_weight_data == 8'h0C) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      chk("flush_third_byte_seen", {31'd0, serial_weight_valid}, 32'd1);
    end
    flush = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_data = 32'h99999999; wr_if.wr_chan = 1'b1; wr_if.wr_nbytes = 2'd0;
    @(posedge clk); #1;
    flush = 1'b0; wr_if.wr_valid = 1'b0;
    bs_model = 0;
    chk("flush_wvalid", {31'd0, serial_weight_valid}, 32'd0);
    chk("flush_lvalid", {31'd0, serial_line_valid}, 32'd0);
    chk("flush_level", {29'd0, fifo_level}, 32'd0);
    chk("flush_bytes", {16'd0, bytes_sent}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    step(20);
    chk("flush_queue", exp_q.size(), 0);
    chk("flush_bytes_after", {16'd0, bytes_sent}, 32'd0);

    // async reset while a byte strobe is high
    gap = 4'd5;
    put(32'h77665544, 1'b1, 2'd0, acc, ac);
    begin
      int n = 0;
      while (!serial_line_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("arst_started", {31'd0, serial_line_valid}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_lvalid", {31'd0, serial_line_valid}, 32'd0);
    chk("arst_ldata", {24'd0, serial_line_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_bytes", {16'd0, bytes_sent}, 32'd0);
    chk("arst_level", {29'd0, fifo_level}, 32'd0);
    exp_q.delete();
    bs_model = 0;
    @(posedge clk); #1;
    step(2);
    reset_n = 1'b1;
    step(15);
    chk("arst_no_bytes", {16'd0, bytes_sent}, 32'd0);

    // after release, the first scenario repeats unchanged
    gap = 4'd0;
    put(32'h44332211, 1'b0, 2'd0, acc, ac);
    exp_word(32'h44332211, 1'b0, 4, -1, ac + 2, 0);
    drain(100);
    chk("post_rst_bytes_sent", {16'd0, bytes_sent}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
